// File: rtl/stq_wq_ctl.sv
// Store-queue write-queue slot controller: in-order allocation of up to two slots per cycle,
// done tracking, and in-order retire of up to two slots. Optional stall counter: STQ_WQ_CTL_STALLCNT_EN.
module stq_wq_ctl #(
    parameter int LOW_WM = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       alloc0_req,
    input  logic       alloc1_req,
    output logic       alloc0_gnt,
    output logic       alloc1_gnt,
    output logic [5:0] alloc0_WQ,
    output logic [5:0] alloc1_WQ,
    input  logic       done0_en,
    input  logic [5:0] done0_WQ,
    input  logic       done1_en,
    input  logic [5:0] done1_WQ,
    input  logic       ret_stall,
    input  logic       flush,
    output logic       upd0_vld,
    output logic       upd1_vld,
    output logic [5:0] upd0_WQ,
    output logic [5:0] upd1_WQ,
    output logic [6:0] count,
    output logic       almost_full
`ifdef STQ_WQ_CTL_STALLCNT_EN
    ,
    output logic [15:0] stall_cnt
`endif
);

    localparam logic [6:0] LOW_WM_W = 7'(LOW_WM);

    logic [6:0]  head_q, tail_q;
    logic [63:0] valid_q, done_q;
    logic [63:0] valid_d, done_d;
    logic [6:0]  free_slots;
    logic [5:0]  head_idx, head_idx1;
    logic        ret0, ret1;
    logic [6:0]  n_gnt, n_ret;

    // Bit 6 of each pointer is the wrap flag, so the 7-bit difference spans 0..64.
    assign count       = tail_q - head_q;
    assign free_slots  = 7'd64 - count;
    assign almost_full = (free_slots < LOW_WM_W);

    always_comb begin
        alloc0_gnt = alloc0_req & (count <= 7'd63) & ~flush;
        alloc1_gnt = alloc1_req & ~flush &
                     (alloc0_req ? (alloc0_gnt & (count <= 7'd62)) : (count <= 7'd63));
    end

    assign alloc0_WQ = tail_q[5:0];
    assign alloc1_WQ = tail_q[5:0] + {5'b0, alloc0_gnt};

    assign head_idx  = head_q[5:0];
    assign head_idx1 = head_q[5:0] + 6'd1;

    // Retire looks only at pre-edge done bits, so a fresh done mark waits one cycle.
    assign ret0 = ~ret_stall & valid_q[head_idx] & done_q[head_idx];
    assign ret1 = ret0 & valid_q[head_idx1] & done_q[head_idx1];

    assign n_gnt = {6'b0, alloc0_gnt} + {6'b0, alloc1_gnt};
    assign n_ret = {6'b0, ret0} + {6'b0, ret1};

    always_comb begin
        valid_d = valid_q;
        done_d  = done_q;
        if (done0_en && valid_q[done0_WQ]) done_d[done0_WQ] = 1'b1;
        if (done1_en && valid_q[done1_WQ]) done_d[done1_WQ] = 1'b1;
        if (ret0) begin
            valid_d[head_idx] = 1'b0;
            done_d[head_idx]  = 1'b0;
        end
        if (ret1) begin
            valid_d[head_idx1] = 1'b0;
            done_d[head_idx1]  = 1'b0;
        end
        if (alloc0_gnt) begin
            valid_d[alloc0_WQ] = 1'b1;
            done_d[alloc0_WQ]  = 1'b0;
        end
        if (alloc1_gnt) begin
            valid_d[alloc1_WQ] = 1'b1;
            done_d[alloc1_WQ]  = 1'b0;
        end
        if (flush) begin
            valid_d = '0;
            done_d  = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_q   <= '0;
            tail_q   <= '0;
            valid_q  <= '0;
            done_q   <= '0;
            upd0_vld <= 1'b0;
            upd1_vld <= 1'b0;
            upd0_WQ  <= '0;
            upd1_WQ  <= '0;
        end else begin
            valid_q  <= valid_d;
            done_q   <= done_d;
            tail_q   <= tail_q + n_gnt;
            head_q   <= flush ? tail_q : (head_q + n_ret);
            upd0_vld <= ret0 & ~flush;
            upd1_vld <= ret1 & ~flush;
            if (ret0 && !flush) begin
                upd0_WQ <= head_idx;
                upd1_WQ <= head_idx1;
            end
        end
    end

`ifdef STQ_WQ_CTL_STALLCNT_EN
    logic stall_evt;

    // A denial under flush is not a capacity stall.
    assign stall_evt = ~flush & ((alloc0_req & ~alloc0_gnt) | (alloc1_req & ~alloc1_gnt));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt <= '0;
        end else if (stall_evt && (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_stq_wq_ctl.sv
// Self-checking bench for stq_wq_ctl: queue-based occupancy model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_stq_wq_ctl;

    localparam int LOW_WM = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       a0, a1;
    logic       d0e, d1e;
    logic [5:0] d0w, d1w;
    logic       stall, flush;

    logic       alloc0_gnt, alloc1_gnt;
    logic [5:0] alloc0_WQ, alloc1_WQ;
    logic       upd0_vld, upd1_vld;
    logic [5:0] upd0_WQ, upd1_WQ;
    logic [6:0] count;
    logic       almost_full;
`ifdef STQ_WQ_CTL_STALLCNT_EN
    logic [15:0] stall_cnt;
`endif

    stq_wq_ctl #(.LOW_WM(LOW_WM)) dut (
        .clk(clk), .rst(rst),
        .alloc0_req(a0), .alloc1_req(a1),
        .alloc0_gnt(alloc0_gnt), .alloc1_gnt(alloc1_gnt),
        .alloc0_WQ(alloc0_WQ), .alloc1_WQ(alloc1_WQ),
        .done0_en(d0e), .done0_WQ(d0w), .done1_en(d1e), .done1_WQ(d1w),
        .ret_stall(stall), .flush(flush),
        .upd0_vld(upd0_vld), .upd1_vld(upd1_vld),
        .upd0_WQ(upd0_WQ), .upd1_WQ(upd1_WQ),
        .count(count), .almost_full(almost_full)
`ifdef STQ_WQ_CTL_STALLCNT_EN
        , .stall_cnt(stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: total-allocation pointer plus a program-order queue of done flags for occupied slots.
    int m_tail;
    bit mq[$];
    bit m_u0v, m_u1v;
    int m_u0w, m_u1w;
    int m_stall;

    function automatic void exp_grants(output bit g0, output bit g1);
        int c;
        c  = mq.size();
        g0 = a0 && (c <= 63) && !flush;
        g1 = a1 && !flush && (a0 ? (g0 && c <= 62) : (c <= 63));
    endfunction

    always @(posedge clk or negedge rst) begin : model
        bit g0, g1, r0, r1;
        int cnt, hd, p;
        if (!rst) begin
            m_tail = 0;
            mq.delete();
            m_u0v = 0; m_u1v = 0;
            m_u0w = 0; m_u1w = 0;
            m_stall = 0;
        end else begin
            exp_grants(g0, g1);
            cnt = mq.size();
            if (!flush && ((a0 && !g0) || (a1 && !g1)) && m_stall < 65535) m_stall++;
            if (flush) begin
                mq.delete();
                m_u0v = 0; m_u1v = 0;
            end else begin
                hd = (m_tail - cnt + 128) % 128;
                r0 = !stall && cnt > 0 && mq[0];
                r1 = r0 && cnt > 1 && mq[1];
                if (d0e) begin
                    p = (int'(d0w) - hd + 128) % 64;
                    if (p < cnt) mq[p] = 1;
                end
                if (d1e) begin
                    p = (int'(d1w) - hd + 128) % 64;
                    if (p < cnt) mq[p] = 1;
                end
                if (r0) begin
                    m_u0w = hd % 64;
                    m_u1w = (hd + 1) % 64;
                    void'(mq.pop_front());
                end
                if (r1) void'(mq.pop_front());
                m_u0v = r0; m_u1v = r1;
                if (g0) mq.push_back(0);
                if (g1) mq.push_back(0);
                m_tail = (m_tail + int'(g0) + int'(g1)) % 128;
            end
        end
    end

    always @(negedge clk) begin : compare
        bit g0, g1;
        int cnt;
        exp_grants(g0, g1);
        cnt = mq.size();
        chk("alloc0_gnt", alloc0_gnt, g0);
        chk("alloc1_gnt", alloc1_gnt, g1);
        if (g0) chk("alloc0_WQ", alloc0_WQ, m_tail % 64);
        if (g1) chk("alloc1_WQ", alloc1_WQ, (m_tail + int'(g0)) % 64);
        chk("count", count, cnt);
        chk("almost_full", almost_full, int'((64 - cnt) < LOW_WM));
        chk("upd0_vld", upd0_vld, m_u0v);
        chk("upd1_vld", upd1_vld, m_u1v);
        chk("upd0_WQ", upd0_WQ, m_u0w);
        chk("upd1_WQ", upd1_WQ, m_u1w);
`ifdef STQ_WQ_CTL_STALLCNT_EN
        chk("stall_cnt", stall_cnt, m_stall);
`endif
    end

    task automatic idle();
        a0 = 0; a1 = 0; d0e = 0; d1e = 0; d0w = '0; d1w = '0;
        stall = 0; flush = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mark_range(input int start, input int n, input bit stl);
        for (int i = 0; i < n; i += 2) begin
            d0e = 1; d0w = 6'((start + i) % 64);
            d1e = (i + 1 < n); d1w = 6'((start + i + 1) % 64);
            stall = stl;
            tick();
        end
        d0e = 0; d1e = 0;
    endtask

    initial begin
        idle();
        rst = 0;
        repeat (2) tick();
        chk("rst_count", count, 0);
        chk("rst_upd0_vld", upd0_vld, 0);
        chk("rst_almost_full", almost_full, 0);
        rst = 1;

        // Dual alloc from empty
        a0 = 1; a1 = 1; #1;
        chk("dual_gnt0", alloc0_gnt, 1);
        chk("dual_gnt1", alloc1_gnt, 1);
        chk("dual_WQ0", alloc0_WQ, 0);
        chk("dual_WQ1", alloc1_WQ, 1);
        tick(); idle();
        chk("dual_count", count, 2);

        // Out-of-order done: slot 1 first, then slot 0
        d0e = 1; d0w = 6'd1; tick(); idle();
        chk("ooo_no_ret_a", upd0_vld, 0);
        tick();
        chk("ooo_no_ret_b", upd0_vld, 0);
        d0e = 1; d0w = 6'd0; tick(); idle();
        chk("done_lat_no_ret", upd0_vld, 0);
        tick();
        chk("ret_upd0_vld", upd0_vld, 1);
        chk("ret_upd1_vld", upd1_vld, 1);
        chk("ret_upd0_WQ", upd0_WQ, 0);
        chk("ret_upd1_WQ", upd1_WQ, 1);
        chk("ret_count", count, 0);
        tick();
        chk("ret_vld_drop", upd0_vld, 0);
        chk("ret_WQ_hold", upd1_WQ, 1);

        // Fill to 63 then 64 (head at slot 2)
        repeat (31) begin a0 = 1; a1 = 1; tick(); end
        a1 = 0; tick(); idle();
        chk("fill63_count", count, 63);
        chk("fill63_af", almost_full, 1);
        a0 = 1; a1 = 1; #1;
        chk("full_gnt0", alloc0_gnt, 1);
        chk("full_gnt1", alloc1_gnt, 0);
        chk("full_WQ0", alloc0_WQ, 1);
        tick();
        chk("full_count", count, 64);
        chk("full_deny0", alloc0_gnt, 0);
        chk("full_deny1", alloc1_gnt, 0);
        idle();

        mark_range(2, 64, 1);
        chk("stalled_count", count, 64);
        stall = 0; a0 = 1; a1 = 1; #1;
        chk("full_ret_gnt0", alloc0_gnt, 0);
        tick();
        chk("full_ret_count", count, 62);
        chk("full_ret_WQ0", upd0_WQ, 2);
        chk("full_ret_WQ1", upd1_WQ, 3);
        tick(); idle();
        chk("alloc_ret_count", count, 62);
        repeat (31) tick();
        chk("drain_count", count, 2);
        flush = 1; tick(); idle();
        chk("flush_clean", count, 0);

        // Wrap: head=tail=63 with wrap clear
        rst = 0; #1;
        chk("rst2_count", count, 0);
        tick(); rst = 1;
        repeat (31) begin a0 = 1; a1 = 1; tick(); end
        a1 = 0; tick(); idle();
        mark_range(0, 63, 0);
        repeat (4) tick();
        chk("pre_wrap_count", count, 0);
        a0 = 1; a1 = 1; #1;
        chk("wrap_WQ0", alloc0_WQ, 63);
        chk("wrap_WQ1", alloc1_WQ, 0);
        tick(); idle();
        chk("wrap_count", count, 2);
        d0e = 1; d0w = 6'd63; d1e = 1; d1w = 6'd0; tick(); idle();
        tick();
        chk("wrap_ret_vld", upd1_vld, 1);
        chk("wrap_ret_WQ0", upd0_WQ, 63);
        chk("wrap_ret_WQ1", upd1_WQ, 0);
        chk("wrap_ret_count", count, 0);
        a0 = 1; #1;
        chk("wrap_tail_idx", alloc0_WQ, 1);
        a0 = 0;

        // Flush with pending work
        repeat (5) begin a0 = 1; a1 = 1; tick(); end
        idle();
        d0e = 1; d0w = 6'd1; d1e = 1; d1w = 6'd2; stall = 1; tick(); idle();
        stall = 1; tick();
        chk("preflush_count", count, 10);
        flush = 1; a0 = 1; a1 = 1; stall = 0; #1;
        chk("flush_gnt0", alloc0_gnt, 0);
        chk("flush_gnt1", alloc1_gnt, 0);
        tick(); idle();
        chk("flush_count", count, 0);
        chk("flush_upd0", upd0_vld, 0);
        chk("flush_upd1", upd1_vld, 0);

        // Done to an invalid slot is dropped
        d0e = 1; d0w = 6'd11; tick(); idle();
        a0 = 1; tick(); idle();
        tick(); tick();
        chk("inv_done_count", count, 1);
        chk("inv_done_vld", upd0_vld, 0);
        flush = 1; tick(); idle();

        // Mixed traffic
        for (int i = 0; i < 300; i++) begin
            int v;
            a0 = (i % 3 != 0);
            a1 = (i % 5 < 3);
            d0e = (i % 2 == 0);
            v = m_tail + 128 - 1 - (i % 5);
            d0w = 6'(v % 64);
            d1e = (i % 3 != 2);
            v = m_tail - mq.size() + 128 + (i % 3);
            d1w = 6'(v % 64);
            stall = ((i % 17) < 3);
            flush = (i % 53 == 52);
            tick();
        end
        idle();

        // Async reset while retiring
        flush = 1; tick(); idle();
        a0 = 1; tick(); idle();
        d0e = 1; d0w = 6'((m_tail + 63) % 64); tick(); idle();
        tick();
        chk("pre_rst_vld", upd0_vld, 1);
        #2 rst = 0; #1;
        chk("async_count", count, 0);
        chk("async_vld", upd0_vld, 0);
        chk("async_WQ0", upd0_WQ, 0);
        chk("async_WQ1", upd1_WQ, 0);
        chk("async_af", almost_full, 0);
        tick(); rst = 1;
        a0 = 1; a1 = 1; #1;
        chk("post_rst_WQ0", alloc0_WQ, 0);
        chk("post_rst_WQ1", alloc1_WQ, 1);
        tick(); idle();
        chk("post_rst_count", count, 2);
        repeat (2) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
